sdram_cmd_sched: RTL and testbench

Two-requester command scheduler in front of the sdramc command port. It arbitrates read/write burst requests round-robin. Each granted request runs as a closed-page ACT -> READ/WRITE -> PRECHARGE sequence on the sdramc valid/ready command interface. Periodic AUTO-REFRESH is inserted at priority between requests.

---
 rtl/sdram_cmd_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_sdram_cmd_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_sched.sv
// sdram_cmd_sched: two-requester round-robin scheduler that drives closed-page
// ACT -> READ/WRITE -> PRECHARGE sequences and periodic AUTO-REFRESH into the
// sdramc valid/ready command port.
module sdram_cmd_sched #(
    parameter int unsigned ADDR_WD      = 13,
    parameter int unsigned COL_WD       = 10,
    parameter int unsigned LEN_WD       = 12,
    parameter int unsigned REF_INTERVAL = 780,
    parameter logic [3:0]  CMD_ACT      = 4'd5,
    parameter logic [3:0]  CMD_RD       = 4'd6,
    parameter logic [3:0]  CMD_WR       = 4'd7,
    parameter logic [3:0]  CMD_PRE      = 4'd2,
    parameter logic [3:0]  CMD_REF      = 4'd1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_valid,
    output logic                m0_ready,
    input  logic                m0_we,
    input  logic [1:0]          m0_ba,
    input  logic [ADDR_WD-1:0]  m0_row,
    input  logic [COL_WD-1:0]   m0_col,
    input  logic [LEN_WD-1:0]   m0_len,
    input  logic                m1_valid,
    output logic                m1_ready,
    input  logic                m1_we,
    input  logic [1:0]          m1_ba,
    input  logic [ADDR_WD-1:0]  m1_row,
    input  logic [COL_WD-1:0]   m1_col,
    input  logic [LEN_WD-1:0]   m1_len,
    output logic                gnt_id,
    output logic                busy,
    output logic                cmd_valid,
    output logic [3:0]          cmd,
    output logic [1:0]          cmd_ba,
    output logic [ADDR_WD-1:0]  row_addr,
    output logic [COL_WD-1:0]   col_addr,
    output logic [LEN_WD-1:0]   r_cmd_len,
    output logic [LEN_WD-1:0]   w_cmd_len,
    input  logic                cmd_ready,
    output logic                ref_miss
);

    localparam int unsigned CNT_WD = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    typedef enum logic [2:0] {IDLE, REF, ACT, RW, PRE} state_t;

    state_t               state_q, state_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [1:0]           cmd_ba_q, cmd_ba_d;
    logic [ADDR_WD-1:0]   row_addr_q, row_addr_d;
    logic [COL_WD-1:0]    col_addr_q, col_addr_d;
    logic [LEN_WD-1:0]    r_len_q, r_len_d;
    logic [LEN_WD-1:0]    w_len_q, w_len_d;
    logic                 gnt_id_q, gnt_id_d;
    logic                 busy_q, busy_d;
    logic                 ref_miss_q, ref_miss_d;
    logic                 ref_pend_q, ref_pend_d;
    logic [CNT_WD-1:0]    ref_cnt_q, ref_cnt_d;
    logic                 fav_q, fav_d;
    logic                 we_q, we_d;
    logic [1:0]           ba_q, ba_d;
    logic [ADDR_WD-1:0]   row_q, row_d;
    logic [COL_WD-1:0]    col_q, col_d;
    logic [LEN_WD-1:0]    len_q, len_d;

    logic ref_tc;
    logic ref_clr;
    logic fire;
    logic req_any;
    logic win1;

    // Arbitration: a lone requester wins, a tie goes to the favoured one
    always_comb begin
        win1    = (m0_valid && m1_valid) ? fav_q : m1_valid;
        req_any = (state_q == IDLE) && !ref_pend_q && (m0_valid || m1_valid);
        fire    = cmd_valid_q && cmd_ready;
        ref_tc  = (ref_cnt_q == CNT_WD'(REF_INTERVAL - 1));
    end

    assign m0_ready = req_any && !win1 && !rst;
    assign m1_ready = req_any && win1 && !rst;

    // Next-state, request latch, refresh bookkeeping and command fields
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        r_len_d     = r_len_q;
        w_len_d     = w_len_q;
        gnt_id_d    = gnt_id_q;
        fav_d       = fav_q;
        we_d        = we_q;
        ba_d        = ba_q;
        row_d       = row_q;
        col_d       = col_q;
        len_d       = len_q;
        ref_clr     = 1'b0;
        cmd_d       = '0;
        cmd_ba_d    = '0;
        row_addr_d  = '0;
        col_addr_d  = '0;

        case (state_q)
            IDLE: begin
                if (ref_pend_q) begin
                    state_d     = REF;
                    cmd_valid_d = 1'b1;
                end else if (req_any) begin
                    state_d     = ACT;
                    cmd_valid_d = 1'b1;
                    gnt_id_d    = win1;
                    fav_d       = ~win1;
                    we_d        = win1 ? m1_we  : m0_we;
                    ba_d        = win1 ? m1_ba  : m0_ba;
                    row_d       = win1 ? m1_row : m0_row;
                    col_d       = win1 ? m1_col : m0_col;
                    len_d       = win1 ? m1_len : m0_len;
                end
            end
            default: begin
                if (fire) begin
                    cmd_valid_d = 1'b0;
                    case (state_q)
                        REF: begin
                            state_d = IDLE;
                            ref_clr = 1'b1;
                        end
                        ACT: begin
                            state_d = RW;
                            if (we_q) w_len_d = len_q;
                            else      r_len_d = len_q;
                        end
                        RW:      state_d = PRE;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    cmd_valid_d = 1'b1;
                end
            end
        endcase

        // Fields follow the state being entered so they are stable while waiting
        case (state_d)
            REF: cmd_d = CMD_REF;
            ACT: begin
                cmd_d      = CMD_ACT;
                cmd_ba_d   = ba_d;
                row_addr_d = row_d;
            end
            RW: begin
                cmd_d      = we_d ? CMD_WR : CMD_RD;
                cmd_ba_d   = ba_d;
                row_addr_d = row_d;
                col_addr_d = col_d;
            end
            PRE: begin
                cmd_d          = CMD_PRE;
                cmd_ba_d       = ba_d;
                row_addr_d     = row_d;
                row_addr_d[10] = 1'b1;
            end
            default: ;
        endcase

        busy_d     = (state_d != IDLE);
        ref_cnt_d  = ref_tc ? '0 : ref_cnt_q + CNT_WD'(1);
        ref_miss_d = ref_tc && ref_pend_q;
        ref_pend_d = ref_tc ? 1'b1 : (ref_clr ? 1'b0 : ref_pend_q);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            cmd_ba_q    <= '0;
            row_addr_q  <= '0;
            col_addr_q  <= '0;
            r_len_q     <= '0;
            w_len_q     <= '0;
            gnt_id_q    <= 1'b0;
            busy_q      <= 1'b0;
            ref_miss_q  <= 1'b0;
            ref_pend_q  <= 1'b0;
            ref_cnt_q   <= '0;
            fav_q       <= 1'b0;
            we_q        <= 1'b0;
            ba_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            cmd_ba_q    <= cmd_ba_d;
            row_addr_q  <= row_addr_d;
            col_addr_q  <= col_addr_d;
            r_len_q     <= r_len_d;
            w_len_q     <= w_len_d;
            gnt_id_q    <= gnt_id_d;
            busy_q      <= busy_d;
            ref_miss_q  <= ref_miss_d;
            ref_pend_q  <= ref_pend_d;
            ref_cnt_q   <= ref_cnt_d;
            fav_q       <= fav_d;
            we_q        <= we_d;
            ba_q        <= ba_d;
            row_q       <= row_d;
            col_q       <= col_d;
            len_q       <= len_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign cmd_ba    = cmd_ba_q;
    assign row_addr  = row_addr_q;
    assign col_addr  = col_addr_q;
    assign r_cmd_len = r_len_q;
    assign w_cmd_len = w_len_q;
    assign gnt_id    = gnt_id_q;
    assign busy      = busy_q;
    assign ref_miss  = ref_miss_q;

endmodule

// File: tb/tb_sdram_cmd_sched.sv
// Bench for sdram_cmd_sched: command-list reference model compared every cycle,
// plus directed sequences with literal expectations.
module tb_sdram_cmd_sched;

    localparam int unsigned AW = 13;
    localparam int unsigned CW = 10;
    localparam int unsigned LW = 12;
    localparam int unsigned N  = 20;

    localparam int K_REF = 0;
    localparam int K_ACT = 1;
    localparam int K_RW  = 2;
    localparam int K_PRE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_valid, m0_ready, m0_we;
    logic [1:0]    m0_ba;
    logic [AW-1:0] m0_row;
    logic [CW-1:0] m0_col;
    logic [LW-1:0] m0_len;
    logic          m1_valid, m1_ready, m1_we;
    logic [1:0]    m1_ba;
    logic [AW-1:0] m1_row;
    logic [CW-1:0] m1_col;
    logic [LW-1:0] m1_len;
    logic          gnt_id, busy, cmd_valid, cmd_ready, ref_miss;
    logic [3:0]    cmd;
    logic [1:0]    cmd_ba;
    logic [AW-1:0] row_addr;
    logic [CW-1:0] col_addr;
    logic [LW-1:0] r_cmd_len, w_cmd_len;

    sdram_cmd_sched #(.REF_INTERVAL(N)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_ba(m0_ba),
        .m0_row(m0_row), .m0_col(m0_col), .m0_len(m0_len),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_ba(m1_ba),
        .m1_row(m1_row), .m1_col(m1_col), .m1_len(m1_len),
        .gnt_id(gnt_id), .busy(busy), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ba(cmd_ba), .row_addr(row_addr), .col_addr(col_addr),
        .r_cmd_len(r_cmd_len), .w_cmd_len(w_cmd_len), .cmd_ready(cmd_ready),
        .ref_miss(ref_miss)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a sequence is a list of commands walked one fire at a time
    int            m_k;
    bit            m_pend, m_fav, m_gnt, m_miss, m_active, m_vis;
    int            m_kind [3];
    int            m_n, m_idx;
    logic          m_we;
    logic [1:0]    m_ba;
    logic [AW-1:0] m_row;
    logic [CW-1:0] m_col;
    logic [LW-1:0] m_len, m_rlen, m_wlen;
    bit            g_take, g_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k = 0; m_pend = 0; m_fav = 0; m_gnt = 0; m_miss = 0; m_active = 0; m_vis = 0;
        m_n = 0; m_idx = 0; m_we = 0; m_ba = '0; m_row = '0; m_col = '0; m_len = '0;
        m_rlen = '0; m_wlen = '0; g_take = 0; g_w = 0;
    endtask

    // Effect of one clock edge on the model, using the inputs of the cycle just ended
    task automatic model_step();
        bit fire, tc, clr;
        fire = m_vis && cmd_ready;
        m_k++;
        tc = (m_k % N) == 0;
        clr = 0;
        m_miss = tc && m_pend;
        if (!m_active) begin
            if (m_pend) begin
                m_active = 1; m_n = 1; m_kind[0] = K_REF; m_idx = 0; m_vis = 1;
            end else if (g_take) begin
                m_we  = g_w ? m1_we  : m0_we;
                m_ba  = g_w ? m1_ba  : m0_ba;
                m_row = g_w ? m1_row : m0_row;
                m_col = g_w ? m1_col : m0_col;
                m_len = g_w ? m1_len : m0_len;
                m_gnt = g_w; m_fav = !g_w;
                m_active = 1; m_n = 3; m_idx = 0; m_vis = 1;
                m_kind[0] = K_ACT; m_kind[1] = K_RW; m_kind[2] = K_PRE;
            end
        end else if (fire) begin
            if (m_kind[m_idx] == K_REF) clr = 1;
            m_idx++;
            m_vis = 0;
            if (m_idx == m_n) m_active = 0;
            else if (m_kind[m_idx] == K_RW) begin
                if (m_we) m_wlen = m_len;
                else      m_rlen = m_len;
            end
        end else begin
            m_vis = 1;
        end
        if (tc) m_pend = 1;
        else if (clr) m_pend = 0;
    endtask

    task automatic compare_regs();
        logic [AW-1:0] r;
        check("cmd_valid", 32'(cmd_valid), 32'(m_vis));
        check("busy", 32'(busy), 32'(m_active));
        check("gnt_id", 32'(gnt_id), 32'(m_gnt));
        check("ref_miss", 32'(ref_miss), 32'(m_miss));
        check("r_cmd_len", 32'(r_cmd_len), 32'(m_rlen));
        check("w_cmd_len", 32'(w_cmd_len), 32'(m_wlen));
        if (m_vis) begin
            r = row_addr;
            case (m_kind[m_idx])
                K_REF: begin
                    check("ref_cmd", 32'(cmd), 32'd1);
                    check("ref_row", 32'(row_addr), 32'd0);
                    check("ref_col", 32'(col_addr), 32'd0);
                end
                K_ACT: begin
                    check("act_cmd", 32'(cmd), 32'd5);
                    check("act_ba", 32'(cmd_ba), 32'(m_ba));
                    check("act_row", 32'(row_addr), 32'(m_row));
                end
                K_RW: begin
                    check("rw_cmd", 32'(cmd), m_we ? 32'd7 : 32'd6);
                    check("rw_ba", 32'(cmd_ba), 32'(m_ba));
                    check("rw_row", 32'(row_addr), 32'(m_row));
                    check("rw_col", 32'(col_addr), 32'(m_col));
                end
                default: begin
                    check("pre_cmd", 32'(cmd), 32'd2);
                    check("pre_ba", 32'(cmd_ba), 32'(m_ba));
                    check("pre_row10", 32'(r[10]), 32'd1);
                end
            endcase
        end
    endtask

    // Settle the inputs of this cycle, predict the grant and check the ready strobes
    task automatic apply();
        #1;
        g_take = 0; g_w = 0;
        if (!m_active && !m_pend && (m0_valid || m1_valid)) begin
            g_take = 1;
            g_w = (m0_valid && m1_valid) ? m_fav : m1_valid;
        end
        check("m0_ready", 32'(m0_ready), 32'(g_take && !g_w));
        check("m1_ready", 32'(m1_ready), 32'(g_take && g_w));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_regs();
    endtask

    task automatic step();
        apply();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_valid = 0; m1_valid = 0; cmd_ready = 0;
        #1;
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_lens", 32'(r_cmd_len) | 32'(w_cmd_len) | 32'(gnt_id) | 32'(ref_miss), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic rand_inputs(input int c);
        m0_valid = ($urandom % 3) != 0;
        m1_valid = ($urandom % 3) != 0;
        m0_we = 1'($urandom); m1_we = 1'($urandom);
        m0_ba = 2'($urandom); m1_ba = 2'($urandom);
        m0_row = AW'($urandom); m1_row = AW'($urandom);
        m0_col = CW'($urandom); m1_col = CW'($urandom);
        m0_len = LW'($urandom); m1_len = LW'($urandom);
        cmd_ready = ((c % 500) < 50) ? 1'b0 : (($urandom % 4) != 0);
    endtask

    initial begin
        int grants[$];
        int misses, refs;
        bit did_rst;
        logic [AW-1:0] r;

        rst = 1'b1;
        m0_we = 0; m0_ba = '0; m0_row = '0; m0_col = '0; m0_len = '0;
        m1_we = 0; m1_ba = '0; m1_row = '0; m1_col = '0; m1_len = '0;
        model_reset();

        // Single write sequence with literal timing
        do_reset();
        cmd_ready = 1;
        m0_valid = 1; m0_we = 1; m0_ba = 2'd1; m0_row = 13'h123; m0_col = 10'h040; m0_len = 12'd8;
        apply();
        check("t1_m0_ready", 32'(m0_ready), 32'd1);
        tick();
        m0_valid = 0;
        check("t1_act_valid", 32'(cmd_valid), 32'd1);
        check("t1_act_cmd", 32'(cmd), 32'd5);
        check("t1_act_row", 32'(row_addr), 32'h123);
        check("t1_act_ba", 32'(cmd_ba), 32'd1);
        step();
        check("t1_wlen", 32'(w_cmd_len), 32'd8);
        step();
        check("t1_wr_cmd", 32'(cmd), 32'd7);
        check("t1_wr_col", 32'(col_addr), 32'h040);
        step();
        step();
        r = row_addr;
        check("t1_pre_cmd", 32'(cmd), 32'd2);
        check("t1_pre_row10", 32'(r[10]), 32'd1);
        step();
        check("t1_idle", 32'(busy), 32'd0);

        // Both requesters continuously valid: grants alternate
        do_reset();
        cmd_ready = 1;
        m0_valid = 1; m1_valid = 1; m0_we = 0; m1_we = 0;
        for (int c = 0; c < 24; c++) begin
            apply();
            check("t2_no_double", 32'(m0_ready && m1_ready), 32'd0);
            if (m0_ready) grants.push_back(0);
            if (m1_ready) grants.push_back(1);
            tick();
        end
        check("t2_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check("t2_grant_order", 32'(grants[i]), 32'(i % 2));

        // ACT held for 5 stalled cycles, then proceeds to RW
        do_reset();
        cmd_ready = 0;
        m1_valid = 1; m1_we = 0; m1_ba = 2'd2; m1_row = 13'h0AA; m1_col = 10'h155; m1_len = 12'd0;
        apply();
        check("t3_m1_ready", 32'(m1_ready), 32'd1);
        tick();
        m1_valid = 0;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(cmd_valid), 32'd1);
            check("t3_hold_cmd", 32'(cmd), 32'd5);
            check("t3_hold_row", 32'(row_addr), 32'h0AA);
            check("t3_hold_ba", 32'(cmd_ba), 32'd2);
            step();
        end
        cmd_ready = 1;
        step();
        check("t3_gap", 32'(cmd_valid), 32'd0);
        step();
        check("t3_rd_cmd", 32'(cmd), 32'd6);
        check("t3_rd_col", 32'(col_addr), 32'h155);
        check("t3_rlen0", 32'(r_cmd_len), 32'd0);

        // Refresh stuck behind a stalled sdramc: misses, then one refresh
        do_reset();
        cmd_ready = 0;
        misses = 0;
        for (int c = 0; c < 65; c++) begin
            step();
            if (ref_miss) misses++;
        end
        check("t5_misses", 32'(misses), 32'd2);
        cmd_ready = 1;
        refs = 0;
        for (int c = 0; c < 10; c++) begin
            apply();
            if (cmd_valid && cmd_ready && cmd == 4'd1) refs++;
            tick();
        end
        check("t5_refs", 32'(refs), 32'd1);

        // Randomized traffic with one asynchronous reset mid-write/read
        do_reset();
        did_rst = 0;
        for (int c = 0; c < 4000; c++) begin
            rand_inputs(c);
            if (!did_rst && c > 1500 && m_active && m_vis && m_kind[m_idx] == K_RW) begin
                did_rst = 1;
                m0_valid = 1;
                #3;
                rst = 1'b1;
                #1;
                check("t6_cmd_valid", 32'(cmd_valid), 32'd0);
                check("t6_busy", 32'(busy), 32'd0);
                check("t6_ready", 32'(m0_ready) | 32'(m1_ready), 32'd0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                m0_valid = 0; m1_valid = 1; cmd_ready = 1;
                apply();
                check("t6_regrant", 32'(m1_ready), 32'd1);
                tick();
                check("t6_act_cmd", 32'(cmd), 32'd5);
                check("t6_act_valid", 32'(cmd_valid), 32'd1);
            end else begin
                step();
            end
        end
        check("t6_reset_hit", 32'(did_rst), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
